// File: rtl/signed_divider_pkg.sv
// Shared definitions for the sequential signed divider: FSM encoding and default width.
package signed_divider_pkg;
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DIVIDE = 2'd1,
    FINISH = 2'd2
  } state_e;

  localparam int DEF_N = 5;
endpackage

// File: rtl/twos_negate.sv
// Conditional two's-complement negate; wraps the most-negative value onto itself.
module twos_negate #(
  parameter int n = 5
) (
  input  logic [n-1:0] a_i,
  input  logic         neg_i,
  output logic [n-1:0] y_o
);
  assign y_o = neg_i ? (~a_i + n'(1)) : a_i;
endmodule

// File: rtl/signed_divider.sv
// Signed restoring divider: magnitudes in, one quotient bit per cycle, signs applied at the end.
module signed_divider
  import signed_divider_pkg::*;
#(
  parameter int n = DEF_N
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [n-1:0] A,
  input  logic [n-1:0] B,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] Q,
  output logic [n-1:0] R,
  output logic         dz,
  output logic         ovf
);
  localparam int CW = $clog2(n + 1);

  state_e         state_q, state_d;
  logic [n:0]     rem_q, rem_d;
  logic [n-1:0]   quo_q, quo_d, dvs_q, dvs_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           sq_q, sq_d, sr_q, sr_d, dzf_q, dzf_d, ovff_q, ovff_d;
  logic [n-1:0]   q_q, q_d, r_q, r_d;
  logic           dz_q, dz_d, ovf_q, ovf_d, done_q, done_d;

  logic [n-1:0]   abs_a, abs_b, q_sgn, r_sgn;
  logic [n:0]     shifted, diff;
  logic           ge;

  twos_negate #(.n(n)) u_abs_a (.a_i(A),               .neg_i(A[n-1]), .y_o(abs_a));
  twos_negate #(.n(n)) u_abs_b (.a_i(B),               .neg_i(B[n-1]), .y_o(abs_b));
  twos_negate #(.n(n)) u_sgn_q (.a_i(quo_q),           .neg_i(sq_q),   .y_o(q_sgn));
  twos_negate #(.n(n)) u_sgn_r (.a_i(rem_q[n-1:0]),    .neg_i(sr_q),   .y_o(r_sgn));

  // One extra remainder bit keeps |A| = 2^(n-1) exact through the shift.
  assign shifted = {rem_q[n-1:0], quo_q[n-1]};
  assign ge      = shifted >= {1'b0, dvs_q};
  assign diff    = shifted - {1'b0, dvs_q};

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    sq_d    = sq_q;
    sr_d    = sr_q;
    dzf_d   = dzf_q;
    ovff_d  = ovff_q;
    q_d     = q_q;
    r_d     = r_q;
    dz_d    = dz_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          rem_d   = '0;
          quo_d   = abs_a;
          dvs_d   = abs_b;
          cnt_d   = CW'(n);
          sq_d    = A[n-1] ^ B[n-1];
          sr_d    = A[n-1];
          dzf_d   = (B == '0);
          ovff_d  = (A == {1'b1, {(n-1){1'b0}}}) && (B == '1);
          state_d = DIVIDE;
        end
      end
      DIVIDE: begin
        rem_d = ge ? diff : shifted;
        quo_d = {quo_q[n-2:0], ge};
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FINISH;
      end
      FINISH: begin
        // With B=0 the remainder already holds |A|, so only Q needs forcing.
        q_d     = dzf_q ? '0 : q_sgn;
        r_d     = r_sgn;
        dz_d    = dzf_q;
        ovf_d   = ovff_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      sq_q    <= 1'b0;
      sr_q    <= 1'b0;
      dzf_q   <= 1'b0;
      ovff_q  <= 1'b0;
      q_q     <= '0;
      r_q     <= '0;
      dz_q    <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      sq_q    <= sq_d;
      sr_q    <= sr_d;
      dzf_q   <= dzf_d;
      ovff_q  <= ovff_d;
      q_q     <= q_d;
      r_q     <= r_d;
      dz_q    <= dz_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign busy = (state_q != IDLE);
  assign done = done_q;
  assign Q    = q_q;
  assign R    = r_q;
  assign dz   = dz_q;
  assign ovf  = ovf_q;
endmodule

// File: doc/signed_divider.md
SIGNED_DIVIDER -- requirements
Module: signed_divider

Interface
REQ-001 SHALL have parameter n, default 5, meaning operand width in bits; two's-complement signed operands; n >= 2.
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-004 SHALL have port start, input, 1, request a division; sampled only in IDLE.
REQ-005 SHALL have port A, input, n, signed dividend; captured in the start cycle.
REQ-006 SHALL have port B, input, n, signed divisor; captured in the start cycle.
REQ-007 SHALL have port busy, output, 1, high from the cycle after an accepted start until done.
REQ-008 SHALL have port done, output, 1, single-cycle pulse when Q/R become valid.
REQ-009 SHALL have port Q, output, n, signed quotient, truncated toward zero.
REQ-010 SHALL have port R, output, n, signed remainder; takes the dividend's sign.
REQ-011 SHALL have port dz, output, 1, divide-by-zero flag for the last result.
REQ-012 SHALL have port ovf, output, 1, overflow flag for the last result (most-negative / -1).

Function
REQ-013 SHALL have states IDLE, DIVIDE and FINISH.
REQ-014 IDLE: start=1 SHALL latch the magnitudes |A| and |B| as n-bit unsigned values, sign flags sQ = A[n-1]^B[n-1] and sR = A[n-1], and count = n, then enter DIVIDE.
REQ-015 DIVIDE SHALL run restoring division, one quotient bit per cycle, MSB first: shift {rem, dividend} left 1; if rem >= |B|, subtract and set the quotient bit to 1; count decrements.
REQ-016 DIVIDE SHALL enter FINISH after exactly n cycles.
REQ-017 FINISH SHALL apply signs (negate Q if sQ, negate R if sR), register Q/R/dz/ovf, pulse done for 1 cycle, and return to IDLE.
REQ-018 Latency SHALL be exactly n+2 cycles from the start-sampling edge to done, independent of operand values.
REQ-019 The internal remainder SHALL be n+1 bits wide so that |A| = 2^(n-1) (most-negative) is handled without loss.
REQ-020 B=0 SHALL give dz=1, Q=0 and R=A, with the same latency as any other division.
REQ-021 A = -2^(n-1) with B = -1 SHALL give ovf=1, Q = -2^(n-1) (wrapped) and R=0.
REQ-022 start while busy SHALL be ignored, with no effect on the operation in progress.
REQ-023 start in the FINISH cycle SHALL be ignored; start in the IDLE cycle immediately after done SHALL be accepted (back-to-back).
REQ-024 Q, R, dz and ovf SHALL hold their values from done until the next done; their changes during DIVIDE are not visible at the ports.

Reset
REQ-025 rst_n=0 at a clock edge SHALL force IDLE, busy=0, done=0, Q=0, R=0, dz=0, ovf=0 and count=0.
REQ-026 Reset mid-operation SHALL abort the division, with no done pulse for the aborted operation.
REQ-027 start SHALL be ignored in any cycle where rst_n=0.

Structure
REQ-028 A shared package SHALL hold the state encoding (IDLE/DIVIDE/FINISH) and the default width constant (5).
REQ-029 A single sub-module twos_negate (parameter n; conditional two's-complement negate) SHALL be used for the input magnitudes and the output sign application.
REQ-030 The target size SHALL be 120-400 lines of RTL, with no combinational divider array.

Verification (n=5)
REQ-031 A=-10 (10110), B=4 -> after 7 cycles done=1, Q=-2 (11110), R=-2 (11110), dz=0, ovf=0.
REQ-032 A=11, B=-3 (11101) -> Q=-3 (11101), R=2 (00010); then A=-10, B=-11 back-to-back -> Q=0, R=-10 (10110).
REQ-033 A=-16 (10000), B=-1 -> ovf=1, Q=10000, R=0; then A=-16, B=3 -> Q=-5 (11011), R=-1 (11111), ovf=0.
REQ-034 A=7, B=0 -> dz=1, Q=0, R=7, latency still 7 cycles.
REQ-035 A=13, B=2 in progress with start pulsed during busy (A=1, B=1) -> the second start is ignored, and the result is Q=6, R=1.
REQ-036 rst_n=0 for 1 cycle at cycle 3 of an operation -> no done, all outputs 0, IDLE; a following start with A=9, B=3 -> Q=3, R=0.
